// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its response buffer.
package fetch_unit_pkg;

   localparam int INSTR_W = 32;

   // FETCH: nothing outstanding; WAIT: one request in flight;
   // DROP: one request in flight whose response must be thrown away.
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      DROP  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order buffer of fetched {pc, instruction} pairs; entry 0 is the head.
module fetch_buffer
   import fetch_unit_pkg::*;
#(
   parameter int PC_W = 9
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  logic               clear,
   input  logic [PC_W-1:0]    push_pc,
   input  logic [INSTR_W-1:0] push_instr,
   output logic               head_valid,
   output logic [PC_W-1:0]    head_pc,
   output logic [INSTR_W-1:0] head_instr,
   output logic [1:0]         occupancy
);

   logic [1:0]         count;
   logic [PC_W-1:0]    e0_pc, e1_pc;
   logic [INSTR_W-1:0] e0_instr, e1_instr;
   logic               pop_en;

   assign pop_en     = pop && (count != 2'd0);
   assign head_valid = (count != 2'd0);
   assign head_pc    = e0_pc;
   assign head_instr = e0_instr;
   assign occupancy  = count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count    <= 2'd0;
         e0_pc    <= '0;
         e1_pc    <= '0;
         e0_instr <= '0;
         e1_instr <= '0;
      end else if (clear) begin
         count <= 2'd0;
      end else if (push && pop_en) begin
         // Occupancy is unchanged; the new word lands behind whatever survives the pop.
         if (count == 2'd1) begin
            e0_pc    <= push_pc;
            e0_instr <= push_instr;
         end else begin
            e0_pc    <= e1_pc;
            e0_instr <= e1_instr;
            e1_pc    <= push_pc;
            e1_instr <= push_instr;
         end
      end else if (push) begin
         if (count == 2'd0) begin
            e0_pc    <= push_pc;
            e0_instr <= push_instr;
         end else begin
            e1_pc    <= push_pc;
            e1_instr <= push_instr;
         end
         count <= count + 2'd1;
      end else if (pop_en) begin
         e0_pc    <= e1_pc;
         e0_instr <= e1_instr;
         count    <= count - 2'd1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues one outstanding memory request at a time, buffers
// returned words for decode, and squashes in-flight work on a branch redirect.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              PC_W     = 9,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               PcSel,
   input  logic [31:0]        BrPC,
   input  logic               stall,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ready,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               if_valid,
   output logic [PC_W-1:0]    if_pc,
   output logic [INSTR_W-1:0] if_instr,
   output logic               flush,
   output fetch_state_e       dbg_state
);

   // Handshakes: a request transfers on a cycle with imem_req && imem_ready;
   // its response is the single imem_rvalid strobe that follows. Decode takes
   // the head instruction on a cycle with if_valid && !stall.

   fetch_state_e    state;
   logic [PC_W-1:0] pc, req_pc, br_target;
   logic [1:0]      occupancy;
   logic            accept, push, pop;
   logic            unused_brpc;

   assign br_target   = {BrPC[PC_W-1:2], 2'b00};
   assign unused_brpc = ^{BrPC[31:PC_W], BrPC[1:0]};

   assign imem_req  = !reset && (state == FETCH) && (occupancy < 2'd2);
   assign imem_addr = pc;
   assign accept    = imem_req && imem_ready;
   assign push      = (state == WAIT) && imem_rvalid && !PcSel;
   assign pop       = if_valid && !stall;
   assign dbg_state = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= FETCH;
         pc     <= RESET_PC;
         req_pc <= '0;
         flush  <= 1'b0;
      end else begin
         flush <= PcSel;
         if (PcSel)
            pc <= br_target;
         else if (accept)
            pc <= pc + PC_W'(4);
         if (accept)
            req_pc <= pc;
         case (state)
            // A request accepted alongside a redirect fetches the wrong path.
            FETCH: if (accept) state <= PcSel ? DROP : WAIT;
            WAIT: begin
               if (imem_rvalid)
                  state <= FETCH;
               else if (PcSel)
                  state <= DROP;
            end
            DROP:    if (imem_rvalid) state <= FETCH;
            default: state <= FETCH;
         endcase
      end
   end

   fetch_buffer #(.PC_W(PC_W)) u_buffer (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .pop        (pop),
      .clear      (PcSel),
      .push_pc    (req_pc),
      .push_instr (imem_rdata),
      .head_valid (if_valid),
      .head_pc    (if_pc),
      .head_instr (if_instr),
      .occupancy  (occupancy)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-level reference model with an expected
// queue of {pc, instr} pairs, checked against the DUT after every clock edge.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int              PC_W     = 9;
   localparam logic [PC_W-1:0] RESET_PC = 9'h000;

   logic               clk = 1'b0;
   logic               reset, PcSel, stall, imem_ready, imem_rvalid;
   logic [31:0]        BrPC;
   logic [INSTR_W-1:0] imem_rdata;
   logic               imem_req, if_valid, flush;
   logic [PC_W-1:0]    imem_addr, if_pc;
   logic [INSTR_W-1:0] if_instr;
   fetch_state_e       dbg_state;

   int checks = 0;
   int failures = 0;

   logic [PC_W+INSTR_W-1:0] exp_q[$];
   logic [PC_W-1:0]         acc_log[$];
   logic [PC_W-1:0]         exp_pc, pend_addr;
   bit                      pend, pend_stale, exp_flush, auto_resp;

   fetch_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .reset       (reset),
      .PcSel       (PcSel),
      .BrPC        (BrPC),
      .stall       (stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .if_valid    (if_valid),
      .if_pc       (if_pc),
      .if_instr    (if_instr),
      .flush       (flush),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] instr_of(input logic [PC_W-1:0] a);
      return {16'hC0DE, 7'b0, a};
   endfunction

   function automatic logic exp_req();
      return !reset && !pend && (exp_q.size() < 2);
   endfunction

   function automatic fetch_state_e exp_state();
      if (!pend) return FETCH;
      return pend_stale ? DROP : WAIT;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("if_valid", if_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         chk("if_pc", if_pc, exp_q[0][PC_W+INSTR_W-1:INSTR_W]);
         chk("if_instr", if_instr, exp_q[0][INSTR_W-1:0]);
      end
      chk("flush", flush, exp_flush);
      chk("imem_req", imem_req, exp_req());
      if (exp_req()) chk("imem_addr", imem_addr, exp_pc);
      chk("state", dbg_state, exp_state());
   endtask

   // One clock: inputs already set by the caller; model advances with the DUT.
   task automatic tick();
      logic            ps, acc, resp;
      logic [PC_W-1:0] br_t, a_model, a_dut;
      if (auto_resp) begin
         imem_rvalid = pend;
         imem_rdata  = pend ? instr_of(pend_addr) : '0;
      end
      ps   = PcSel;
      br_t = {BrPC[PC_W-1:2], 2'b00};
      if (exp_q.size() != 0 && !stall && !ps) void'(exp_q.pop_front());
      acc     = exp_req() && imem_ready;
      a_model = exp_pc;
      a_dut   = imem_addr;
      resp    = imem_rvalid;
      @(posedge clk);
      #1;
      if (resp && pend) begin
         if (!pend_stale && !ps) exp_q.push_back({pend_addr, instr_of(pend_addr)});
         pend = 0;
      end
      if (ps) begin
         exp_q.delete();
         exp_pc = br_t;
         if (pend) pend_stale = 1;
      end else if (acc) begin
         exp_pc = exp_pc + 9'd4;
      end
      if (acc) begin
         pend       = 1;
         pend_addr  = a_model;
         pend_stale = ps;
         acc_log.push_back(a_dut);
      end
      exp_flush = ps;
      check_outputs();
   endtask

   task automatic respond();
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(pend_addr);
      tick();
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
   endtask

   // Reset is raised between clock edges so the checks see its asynchronous effect.
   task automatic do_reset();
      #2 reset = 1'b1;
      #1;
      pend      = 0;
      pend_stale = 0;
      exp_flush = 0;
      exp_pc    = RESET_PC;
      exp_q.delete();
      acc_log.delete();
      check_outputs();
      chk("rst_if_pc", if_pc, 0);
      chk("rst_if_instr", if_instr, 0);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      reset       = 1'b0;
      PcSel       = 1'b0;
      BrPC        = '0;
      stall       = 1'b0;
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      auto_resp   = 1;
      do_reset();

      // Streaming fetch from reset
      imem_ready = 1'b1;
      repeat (8) tick();
      chk("seq_addr0", acc_log[0], 9'h000);
      chk("seq_addr1", acc_log[1], 9'h004);
      chk("seq_addr2", acc_log[2], 9'h008);

      // Decode stall fills the buffer, then drains in order
      stall = 1'b1;
      repeat (6) tick();
      chk("stall_req", imem_req, 0);
      chk("stall_valid", if_valid, 1);
      stall      = 1'b0;
      imem_ready = 1'b0;
      repeat (4) tick();
      chk("drained", if_valid, 0);

      // Redirect while waiting; late response dropped
      auto_resp  = 0;
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      tick();
      PcSel = 1'b1;
      BrPC  = 32'h0000_0123;
      tick();
      PcSel = 1'b0;
      chk("redir_flush", flush, 1);
      chk("redir_state", dbg_state, DROP);
      tick();
      chk("flush_pulse", flush, 0);
      respond();
      chk("late_drop", if_valid, 0);
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      chk("redir_addr", acc_log[$], 9'h120);
      respond();
      chk("target_valid", if_valid, 1);
      chk("target_pc", if_pc, 9'h120);
      repeat (2) tick();

      // Redirect coincident with the response
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      PcSel = 1'b1;
      BrPC  = 32'h0000_0040;
      respond();
      PcSel = 1'b0;
      chk("coinc_state", dbg_state, FETCH);
      chk("coinc_valid", if_valid, 0);
      chk("coinc_addr", imem_addr, 9'h040);

      // Redirect in the same cycle a request is accepted
      imem_ready = 1'b1;
      PcSel      = 1'b1;
      BrPC       = 32'h0000_00A0;
      tick();
      PcSel      = 1'b0;
      imem_ready = 1'b0;
      chk("stale_acc_state", dbg_state, DROP);
      chk("stale_acc_req", imem_req, 0);
      respond();
      chk("stale_acc_valid", if_valid, 0);
      chk("stale_acc_addr", imem_addr, 9'h0A0);

      // Alignment of the target and pc wrap at the top of the space
      PcSel = 1'b1;
      BrPC  = 32'hFFFF_F1FF;
      tick();
      PcSel = 1'b0;
      chk("align", imem_addr, 9'h1FC);
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      respond();
      chk("wrap_addr", imem_addr, 9'h000);
      chk("wrap_pc", if_pc, 9'h1FC);
      tick();

      // Second redirect while already dropping only moves pc
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      PcSel = 1'b1;
      BrPC  = 32'h0000_0080;
      tick();
      BrPC  = 32'h0000_0090;
      tick();
      PcSel = 1'b0;
      chk("drop_redir_state", dbg_state, DROP);
      respond();
      chk("drop_redir_addr", imem_addr, 9'h090);
      chk("drop_redir_valid", if_valid, 0);

      // Reset in the middle of an outstanding request
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      do_reset();
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      tick();
      imem_rvalid = 1'b0;
      chk("rst_stale_valid", if_valid, 0);
      chk("rst_addr", imem_addr, RESET_PC);
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      chk("rst_first_acc", acc_log[0], RESET_PC);
      respond();
      chk("rst_first_pc", if_pc, RESET_PC);
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL expose parameter PC_W, default 9, instruction-address width in bits.
REQ-002 The block SHALL expose parameter RESET_PC, default 0, fetch address after reset.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 PcSel  input  1  redirect request from branch resolution.
REQ-007 BrPC  input  32  redirect target; only bits [PC_W-1:0] are used.
REQ-008 stall  input  1  decode cannot accept the current instruction.
REQ-009 imem_req  output  1  fetch request to instruction memory.
REQ-010 imem_addr  output  PC_W  fetch address, valid while imem_req=1.
REQ-011 imem_ready  input  1  memory accepts the request this cycle.
REQ-012 imem_rvalid  input  1  one-cycle response strobe; requests complete in order, at most one outstanding.
REQ-013 imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-014 if_valid  output  1  if_pc/if_instr hold a valid instruction.
REQ-015 if_pc  output  PC_W  address of the presented instruction.
REQ-016 if_instr  output  32  presented instruction word.
REQ-017 flush  output  1  registered one-cycle pulse, the cycle after PcSel=1.

Function
REQ-018 Fetch PC register pc SHALL advance by pc+4 modulo 2^PC_W (wrap, no carry out) on each accepted sequential request.
REQ-019 FSM SHALL have three states: FETCH (no request outstanding), WAIT (one outstanding), DROP (one outstanding, response to be discarded).
REQ-020 In FETCH, imem_req SHALL be 1 if and only if buffer occupancy < 2; imem_addr SHALL equal pc.
REQ-021 A request is accepted when imem_req && imem_ready: FETCH->WAIT, req_pc<=pc, pc<=pc+4.
REQ-022 In WAIT, imem_rvalid SHALL push {req_pc, imem_rdata} into the 2-entry buffer and return to FETCH.
REQ-023 The buffer head SHALL drive if_valid/if_pc/if_instr; the head pops when if_valid && !stall; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-024 Latency: from request acceptance to if_valid=1 SHALL be one cycle after imem_rvalid when the buffer is empty.
REQ-025 Redirect (PcSel=1) SHALL take priority over stall, push and pop: pc<=BrPC[PC_W-1:0] with bits [1:0] forced to 0, buffer cleared, if_valid=0 the next cycle.
REQ-026 Redirect in WAIT without same-cycle imem_rvalid: next state DROP.
REQ-027 Redirect in WAIT with same-cycle imem_rvalid: response discarded; next state FETCH.
REQ-028 Redirect in FETCH with same-cycle acceptance: the accepted request is stale; next state DROP; pc SHALL still load the target.
REQ-029 In DROP, imem_rvalid SHALL be discarded and the FSM returns to FETCH; a further PcSel in DROP updates pc only.
REQ-030 imem_req SHALL be 0 in WAIT and DROP.
REQ-031 If stall holds with buffer full, no request SHALL issue and outputs SHALL hold stable.

Reset
REQ-032 On reset assertion, asynchronously: state=FETCH, pc=RESET_PC, buffer empty, if_valid=0, if_pc=0, if_instr=0, flush=0, imem_req=0.
REQ-033 Reset asserted mid-transaction SHALL abandon the outstanding request; no response SHALL be pushed until a new request is accepted after reset release.

Structure
REQ-034 A shared package SHALL hold the FSM state enum (FETCH, WAIT, DROP) and constant INSTR_W=32.
REQ-035 The 2-entry buffer SHALL be a sub-module fetch_buffer with push, pop, clear, and occupancy outputs.

Verification
REQ-036 Reset release, imem_ready=1, rvalid one cycle after accept -> imem_addr 0x000, 0x004, 0x008; if_pc follows the same sequence.
REQ-037 stall=1 for 6 cycles -> exactly 2 instructions buffered, imem_req=0, if_pc unchanged; stall release -> both drain in order.
REQ-038 PcSel=1, BrPC=0x00000123 while WAIT -> flush pulse, next imem_addr=0x120, the late response is discarded, and if_valid=0 until the 0x120 fetch returns.
REQ-039 PcSel coincident with imem_rvalid -> the word is not presented; state goes to FETCH; next address is the target.
REQ-040 pc=0x1FC with PC_W=9 -> next imem_addr=0x000.
REQ-041 reset asserted during WAIT, then released -> first imem_addr=RESET_PC; the stale rvalid produces no if_valid.
